mem_rd_agent: RTL and testbench

MEM_RD_AGENT -- requirements
Module: mem_rd_agent

---
 rtl/mem_rd_agent.sv | 132 +++++++++++++
 tb/tb_mem_rd_agent.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_agent.sv
// mem_rd_agent: streams AXI read bursts across [ADDR_BASE, ADDR_HIGH) in a loop
// and pushes every returned beat into a downstream FIFO. Bursts in flight are
// bounded by OUTSTANDING_MAX; stop lets the bursts already issued finish first.
module mem_rd_agent #(
  parameter logic [31:0] ADDR_BASE       = 32'h4000_0000,
  parameter logic [31:0] ADDR_HIGH       = 32'h4000_1000,
  parameter int          OUTSTANDING_MAX = 16,
  parameter int          BURST_BEATS     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        fifo_wrreq,
  input  logic        fifo_full,
  output logic [63:0] fifo_wdata,
  output logic [31:0] dbg_beat_cnt,
  output logic [31:0] dbg_err_cnt,
  output logic [4:0]  outstanding
);

  // state | meaning
  // IDLE  | nothing issued; R beats still forwarded to the FIFO
  // RUN   | issuing bursts while outstanding < OUTSTANDING_MAX
  // DRAIN | no new bursts; wait for pending AR and all rlasts
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [32:0] BURST_BYTES = 33'(BURST_BEATS * 8);
  localparam logic [4:0]  OUT_MAX     = 5'(OUTSTANDING_MAX);

  state_t      state;
  state_t      state_nxt;
  logic        ar_hs;
  logic        r_hs;
  logic        rlast_hs;
  logic [32:0] araddr_inc;
  logic [31:0] araddr_nxt;

  assign m_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;

  // The FIFO is the only backpressure on R, so beats are accepted even in IDLE.
  assign m_axi_rready = !fifo_full;
  assign r_hs         = m_axi_rvalid & m_axi_rready;
  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign rlast_hs     = r_hs & m_axi_rlast;
  assign fifo_wrreq   = r_hs & ~rst;
  assign fifo_wdata   = m_axi_rdata;

  // 33-bit sum so a window ending near 4 GiB still wraps correctly.
  assign araddr_inc = {1'b0, m_axi_araddr} + BURST_BYTES;
  assign araddr_nxt = (araddr_inc >= {1'b0, ADDR_HIGH}) ? ADDR_BASE : araddr_inc[31:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DRAIN leaves only once no AR is pending and nothing is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   if (outstanding == 5'd0 && !m_axi_arvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

  // AR channel: raise only while staying in RUN with credit, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= ADDR_BASE;
    end else begin
      if (state == IDLE && state_nxt == RUN) m_axi_araddr <= ADDR_BASE;
      else if (ar_hs)                        m_axi_araddr <= araddr_nxt;
      if (ar_hs)
        m_axi_arvalid <= 1'b0;
      else if (!m_axi_arvalid && state == RUN && state_nxt == RUN && outstanding < OUT_MAX)
        m_axi_arvalid <= 1'b1;
    end
  end

  // In-flight burst count; an rlast with nothing tracked (e.g. after reset) is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 5'd0;
    end else begin
      case ({ar_hs, rlast_hs && (outstanding != 5'd0)})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Debug counters: cleared by start in IDLE, otherwise count every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_beat_cnt <= 32'd0;
      dbg_err_cnt  <= 32'd0;
    end else if (state == IDLE && start) begin
      dbg_beat_cnt <= 32'd0;
      dbg_err_cnt  <= 32'd0;
    end else if (r_hs) begin
      dbg_beat_cnt <= dbg_beat_cnt + 32'd1;
      if (m_axi_rresp != 2'b00) dbg_err_cnt <= dbg_err_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_rd_agent.sv
// tb_mem_rd_agent: directed scenarios with hand-computed expectations.
module tb_mem_rd_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, busy;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        fifo_wrreq, fifo_full;
  logic [63:0] fifo_wdata;
  logic [31:0] dbg_beat_cnt, dbg_err_cnt;
  logic [4:0]  outstanding;

  int          checks = 0;
  int          errors = 0;
  int          ar_cnt = 0;
  int          wr_cnt = 0;
  int          ar_base = 0;
  int          wr_base = 0;
  logic [31:0] ar_log[$];
  logic [63:0] last_wdata = 64'd0;

  localparam logic [63:0] D0 = 64'hA5A5_0000_0000_0000;

  mem_rd_agent dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata),
    .dbg_beat_cnt(dbg_beat_cnt), .dbg_err_cnt(dbg_err_cnt), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Record every AR handshake address in order.
  always @(posedge clk) begin
    if (m_axi_arvalid && m_axi_arready) begin
      ar_log.push_back(m_axi_araddr);
      ar_cnt <= ar_cnt + 1;
    end
  end

  // Count FIFO writes and keep the last written word.
  always @(posedge clk) begin
    if (fifo_wrreq) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= fifo_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 64'd0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ar_base = ar_cnt;
    wr_base = wr_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_ar(input int n, input string tag);
    int g;
    g = 0;
    while ((ar_cnt - ar_base) < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 64'((ar_cnt - ar_base) >= n), 64'd1);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
    @(negedge clk);
    m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rresp = resp; m_axi_rlast = last;
  endtask

  task automatic r_idle();
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
  endtask

  task automatic send_burst(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) drive_beat(base + 64'(i), 2'b00, i == n - 1);
    r_idle();
  endtask

  initial begin
    logic [31:0] held;

    // Reset values, with an R beat presented while in reset.
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = D0;
    fifo_full = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 32'h4000_0000);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_beat_cnt", dbg_beat_cnt, 0);
    chk("rst_err_cnt", dbg_err_cnt, 0);
    chk("rst_rready", m_axi_rready, 1);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("arlen", m_axi_arlen, 8'd15);
    chk("arsize", m_axi_arsize, 3'b011);
    chk("arburst", m_axi_arburst, 2'b01);

    // Start and stop together in IDLE stays IDLE.
    do_reset();
    m_axi_arready = 1'b1;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_idle_busy", busy, 0);
    chk("both_idle_ar", 64'(ar_cnt - ar_base), 0);

    // Full pass of 32 bursts, then address wraps.
    do_reset();
    m_axi_arready = 1'b1;
    pulse_start();
    chk("run_busy", busy, 1);
    for (int b = 0; b < 32; b++) begin
      wait_ar(b + 1, "pass_ar_wait");
      chk("pass_araddr", ar_log[ar_base + b], 32'h4000_0000 + 32'(b * 128));
      send_burst(16, D0 + 64'(b * 16));
    end
    chk("pass_beat_cnt", dbg_beat_cnt, 512);
    chk("pass_err_cnt", dbg_err_cnt, 0);
    chk("pass_wr_cnt", 64'(wr_cnt - wr_base), 512);
    chk("pass_last_wdata", last_wdata, D0 + 64'd511);
    wait_ar(33, "wrap_ar_wait");
    chk("wrap_araddr", ar_log[ar_base + 32], 32'h4000_0000);

    // No R returned: issue stops at 16.
    do_reset();
    m_axi_arready = 1'b1;
    pulse_start();
    repeat (60) @(negedge clk);
    chk("cap_ar_cnt", 64'(ar_cnt - ar_base), 16);
    chk("cap_outstanding", outstanding, 16);
    chk("cap_arvalid", m_axi_arvalid, 0);
    send_burst(16, D0);
    repeat (6) @(negedge clk);
    chk("refill_ar_cnt", 64'(ar_cnt - ar_base), 17);
    chk("refill_outstanding", outstanding, 16);
    chk("refill_arvalid", m_axi_arvalid, 0);

    // Pending AR holds stable; AR and rlast handshakes in one cycle.
    m_axi_arready = 1'b0;
    send_burst(16, D0);
    repeat (2) @(negedge clk);
    chk("hold_arvalid", m_axi_arvalid, 1);
    chk("hold_araddr", m_axi_araddr, 32'h4000_0880);
    held = m_axi_araddr;
    repeat (3) @(negedge clk);
    chk("hold_arvalid2", m_axi_arvalid, 1);
    chk("hold_araddr2", m_axi_araddr, held);
    chk("hold_outstanding", outstanding, 15);
    for (int i = 0; i < 15; i++) drive_beat(D0 + 64'(i), 2'b00, 1'b0);
    drive_beat(D0 + 64'd15, 2'b00, 1'b1);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
    chk("same_cycle_outstanding", outstanding, 15);
    chk("same_cycle_ar_cnt", 64'(ar_cnt - ar_base), 18);

    // FIFO full for 10 cycles mid-burst.
    do_reset();
    m_axi_arready = 1'b1;
    pulse_start();
    wait_ar(1, "full_ar_wait");
    for (int i = 0; i < 16; i++) begin
      drive_beat(D0 + 64'(i), 2'b00, i == 15);
      if (i == 5) begin
        fifo_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
          if (k > 0) @(negedge clk);
          #1;
          chk("full_rready", m_axi_rready, 0);
          chk("full_wrreq", fifo_wrreq, 0);
        end
        chk("full_beat_hold", dbg_beat_cnt, 5);
        @(negedge clk);
        fifo_full = 1'b0;
      end
    end
    r_idle();
    chk("full_beat_cnt", dbg_beat_cnt, 16);
    chk("full_wr_cnt", 64'(wr_cnt - wr_base), 16);
    chk("full_last_wdata", last_wdata, D0 + 64'd15);

    // Stop with 3 bursts outstanding.
    do_reset();
    m_axi_arready = 1'b1;
    pulse_start();
    wait_ar(3, "stop_ar_wait");
    stop = 1'b1;
    chk("stop_no_pending", m_axi_arvalid, 0);
    @(negedge clk); stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("stop_ar_cnt", 64'(ar_cnt - ar_base), 3);
    chk("stop_outstanding", outstanding, 3);
    chk("stop_busy", busy, 1);
    send_burst(16, D0);
    send_burst(16, D0);
    chk("drain_busy2", busy, 1);
    chk("drain_outstanding2", outstanding, 1);
    for (int i = 0; i < 16; i++) drive_beat(D0 + 64'(i), 2'b00, i == 15);
    r_idle();
    chk("drain_outstanding0", outstanding, 0);
    chk("drain_busy_last", busy, 1);
    @(negedge clk);
    chk("drain_idle", busy, 0);
    chk("drain_ar_cnt", 64'(ar_cnt - ar_base), 3);

    // Error response beat still written.
    do_reset();
    pulse_start();
    drive_beat(D0 + 64'h77, 2'b10, 1'b0);
    #1;
    chk("err_wrreq", fifo_wrreq, 1);
    chk("err_wdata", fifo_wdata, D0 + 64'h77);
    drive_beat(D0 + 64'h78, 2'b00, 1'b0);
    r_idle();
    chk("err_cnt", dbg_err_cnt, 1);
    chk("err_beat_cnt", dbg_beat_cnt, 2);
    chk("err_wr_cnt", 64'(wr_cnt - wr_base), 2);

    // Asynchronous reset mid-burst with 5 outstanding.
    do_reset();
    m_axi_arready = 1'b1;
    pulse_start();
    wait_ar(5, "arst_ar_wait");
    m_axi_arready = 1'b0;
    chk("arst_outstanding5", outstanding, 5);
    for (int i = 0; i < 3; i++) drive_beat(D0 + 64'(i), 2'b00, 1'b0);
    drive_beat(D0 + 64'd3, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_arvalid", m_axi_arvalid, 0);
    chk("arst_araddr", m_axi_araddr, 32'h4000_0000);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_beat_cnt", dbg_beat_cnt, 0);
    chk("arst_err_cnt", dbg_err_cnt, 0);
    chk("arst_rready", m_axi_rready, 1);
    chk("arst_wrreq", fifo_wrreq, 0);
    @(negedge clk);
    rst = 1'b0;
    m_axi_rlast = 1'b1;
    wr_base = wr_cnt;
    #1;
    chk("post_rst_wrreq", fifo_wrreq, 1);
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wr_cnt", 64'(wr_cnt - wr_base), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
